muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit completing the RV32M extension beside the single-cycle ALU. It accepts one operation per handshake and executes it over a fixed number of cycles. Multiply uses radix-2 shift-add; divide uses radix-2 restoring division. The result is held until the consumer takes it. It sits in the execute stage and stalls the pipeline through the valid/ready pair.

## Interface
- XLEN, 32: operand and result width; must be ≥ 4 and a power of two.
- clk  in  1  the single clock.
- rst  in  1  synchronous, active-high reset.
- i_MulDivControl_8  in  8  one-hot op, MSB→LSB {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU}.
- i_Operand1  in  XLEN  rs1 (multiplicand / dividend).
- i_Operand2  in  XLEN  rs2 (multiplier / divisor).
- i_Valid  in  1  request valid.
- o_Ready  out  1  unit can accept a request (IDLE and not rst).
- i_Flush  in  1  abort any in-flight op.
- o_Result  out  XLEN  registered result.
- o_Valid  out  1  o_Result valid.
- i_Ready  in  1  consumer takes the result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: state=IDLE, o_Valid=0, o_Result=0, counter=0. o_Ready=0 while rst=1 and 1 on the first cycle after.
- **IDLE**
  - Accept when i_Valid & o_Ready at a clock edge.
  - Latch the op and operand signs.
  - Latch the magnitudes: |op| for signed operands, raw value for unsigned.
  - Load counter=XLEN, then go to CALC.
- **Signedness**
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - MUL: low half, identical for either sign.
  - DIV, REM: both operands signed.
- **Fast path (IDLE→DONE in one cycle, no CALC)**
  - Divisor = 0: quotient = all-ones; remainder = dividend.
  - Signed overflow (DIV/REM with dividend = 1<<(XLEN-1) and divisor = all-ones): quotient = dividend; remainder = 0.
  - Control = 0 with i_Valid: result 0.
  - Multi-hot control is illegal; an assertion flags it.
- **CALC** performs one iteration per cycle and decrements the counter. On the cycle the counter equals 1, go to FIX.
  - Multiply: 2·XLEN product register. If the multiplier LSB is 1, add the multiplicand into the upper half, then shift right by 1 (carry preserved).
  - Divide: remainder/quotient pair. Shift left 1, trial-subtract the divisor; if non-negative, keep the difference and set quotient LSB=1.
- **FIX** applies the result sign:
  - Multiply sign = s1 ^ s2 (s2 forced 0 for MULHSU/MULHU). The full 2·XLEN product is negated, so high halves are exact.
  - Quotient sign = s1 ^ s2; remainder sign = s1.
  - Select the low half (MUL) or high half (MULH*), quotient or remainder. Register it into o_Result and go to DONE.
- **DONE**: o_Valid=1; o_Result is stable. On i_Ready go to IDLE and drop o_Valid. No accept in the same cycle.
- **i_Flush**: from any state go to IDLE at the next edge and clear o_Valid; o_Result keeps its old value. Flush has priority over accept and over completion. rst has priority over flush.

## Timing
- Iterative latency: handshake at edge t → o_Valid high from cycle t+XLEN+2 (CALC for XLEN cycles, then FIX).
- Fast-path latency: o_Valid high from cycle t+1.
- Minimum initiation interval: latency + 1. The IDLE cycle after DONE is mandatory.
- o_Ready is combinational from state only, with no dependence on i_Valid.
- o_Result and o_Valid are registered, with no combinational input→output paths.
- Backpressure: o_Valid and o_Result hold indefinitely while i_Ready=0.
- Counter width: $clog2(XLEN)+1. It never wraps; it reaches 1 exactly once per op.
- Adder/subtractor width: XLEN+1 (carry/borrow bit). Negation is two's complement over the full register width.

## Structure
- Shared package muldiv_pkg holds:
  - op-bit index localparams matching i_MulDivControl_8 order;
  - the state enum {IDLE, CALC, FIX, DONE};
  - the XLEN-derived counter-width function.
- One sub-module, muldiv_step: combinational single iteration, selected by an is_div input. It takes the accumulator/remainder, shifter and operand magnitude, and returns the next values. Instantiated once.
- Top level holds the FSM, counter, sign latches, FIX negation/selection and handshake.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB at cycle t+34; MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU x / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, o_Valid at t+1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM of the same operands → 0.
- i_Ready=0 for 10 cycles in DONE → o_Valid/o_Result stable, o_Ready=0; i_Ready=1 → IDLE next cycle, new accept the cycle after.
- i_Flush at cycle 5 of CALC → IDLE next edge, o_Valid never rises; rst mid-CALC → o_Valid=0, o_Result=0; back-to-back random ops (XLEN=32 and XLEN=8) checked against a reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit: op-bit indices,
// FSM state encodings and the iteration-counter width helper.
package muldiv_pkg;

    // Bit positions inside i_MulDivControl_8, MSB to LSB.
    localparam int unsigned OP_MUL    = 7;
    localparam int unsigned OP_MULH   = 6;
    localparam int unsigned OP_MULHSU = 5;
    localparam int unsigned OP_MULHU  = 4;
    localparam int unsigned OP_DIV    = 3;
    localparam int unsigned OP_DIVU   = 2;
    localparam int unsigned OP_REM    = 1;
    localparam int unsigned OP_REMU   = 0;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

    // Wide enough to hold the value XLEN itself.
    function automatic int unsigned cnt_width(input int unsigned xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide, sharing a single
// XLEN+1 bit adder.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] shf,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] shf_next
);

    logic [XLEN:0] add_a;
    logic [XLEN:0] add_b;
    logic [XLEN:0] add_cin;
    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic          nonneg;

    always_comb begin
        add_a   = is_div ? {acc, shf[XLEN-1]} : {1'b0, acc};
        // Divide subtracts: a + ~{0,d} + 1.
        add_b   = is_div ? {1'b1, ~opnd} : {1'b0, opnd};
        add_cin = {{XLEN{1'b0}}, is_div};
        sum     = add_a + add_b + add_cin;
    end

    always_comb begin
        nonneg   = ~sum[XLEN];
        part     = shf[0] ? sum : add_a;
        acc_next = '0;
        shf_next = '0;
        if (is_div) begin
            // Partial remainder is always below the divisor, so the top bit is a true sign.
            acc_next = nonneg ? sum[XLEN-1:0] : add_a[XLEN-1:0];
            shf_next = {shf[XLEN-2:0], nonneg};
        end else begin
            acc_next = part[XLEN:1];
            shf_next = {part[0], shf[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Operands run as magnitudes through CALC; FIX restores the sign and picks the half.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      i_MulDivControl_8,
    input  logic [XLEN-1:0] i_Operand1,
    input  logic [XLEN-1:0] i_Operand2,
    input  logic            i_Valid,
    output logic            o_Ready,
    input  logic            i_Flush,
    output logic [XLEN-1:0] o_Result,
    output logic            o_Valid,
    input  logic            i_Ready
);

    localparam int unsigned CW = cnt_width(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      op_q;
    logic            s1_q;
    logic            s2_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] shf_q;
    logic [XLEN-1:0] mag_q;
    logic [XLEN-1:0] result_q;
    logic            valid_q;

    logic [XLEN-1:0] acc_nx;
    logic [XLEN-1:0] shf_nx;

    // Request decode
    logic [7:0]      ctl;
    logic            op1_signed;
    logic            op2_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            req_div;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        ctl        = i_MulDivControl_8;
        op1_signed = ctl[OP_MULH] | ctl[OP_MULHSU] | ctl[OP_DIV] | ctl[OP_REM];
        op2_signed = ctl[OP_MULH] | ctl[OP_DIV] | ctl[OP_REM];
        a_neg      = op1_signed & i_Operand1[XLEN-1];
        b_neg      = op2_signed & i_Operand2[XLEN-1];
        a_mag      = a_neg ? -i_Operand1 : i_Operand1;
        b_mag      = b_neg ? -i_Operand2 : i_Operand2;
        req_div    = |ctl[OP_DIV:OP_REMU];
        div_zero   = (i_Operand2 == '0);
        div_ovf    = (ctl[OP_DIV] | ctl[OP_REM]) && (i_Operand1 == MIN_NEG) &&
                     (i_Operand2 == '1);
        fast       = (ctl == 8'd0) || (req_div && (div_zero || div_ovf));
        fast_res   = '0;
        if (ctl == 8'd0) begin
            fast_res = '0;
        end else if (div_zero) begin
            fast_res = (ctl[OP_DIV] | ctl[OP_DIVU]) ? '1 : i_Operand1;
        end else if (div_ovf) begin
            fast_res = ctl[OP_DIV] ? i_Operand1 : '0;
        end
    end

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div   (|op_q[OP_DIV:OP_REMU]),
        .acc      (acc_q),
        .shf      (shf_q),
        .opnd     (mag_q),
        .acc_next (acc_nx),
        .shf_next (shf_nx)
    );

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod     = {acc_q, shf_q};
        prod_fix = (s1_q ^ s2_q) ? -prod : prod;
        quo_fix  = (s1_q ^ s2_q) ? -shf_q : shf_q;
        rem_fix  = s1_q ? -acc_q : acc_q;
        if (op_q[OP_MUL]) begin
            fix_res = prod_fix[XLEN-1:0];
        end else if (op_q[OP_MULH] | op_q[OP_MULHSU] | op_q[OP_MULHU]) begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end else if (op_q[OP_DIV] | op_q[OP_DIVU]) begin
            fix_res = quo_fix;
        end else begin
            fix_res = rem_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            acc_q    <= '0;
            shf_q    <= '0;
            mag_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (i_Flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Valid) begin
                        op_q <= ctl;
                        s1_q <= a_neg;
                        s2_q <= b_neg;
                        if (fast) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            acc_q   <= '0;
                            cnt_q   <= CW'(XLEN);
                            state_q <= CALC;
                            // Divide shifts the dividend out; multiply shifts the multiplier.
                            if (req_div) begin
                                shf_q <= a_mag;
                                mag_q <= b_mag;
                            end else begin
                                shf_q <= b_mag;
                                mag_q <= a_mag;
                            end
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_nx;
                    shf_q <= shf_nx;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (i_Ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Ready  = (state_q == IDLE) && !rst;
    assign o_Result = result_q;
    assign o_Valid  = valid_q;

    a_ctl_onehot: assert property (@(posedge clk) disable iff (rst)
        (i_Valid && o_Ready) |-> $onehot0(i_MulDivControl_8));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector and reference-model bench for muldiv_unit at XLEN=32 and XLEN=8.
module tb_muldiv_unit;

    localparam logic [7:0] C_MUL    = 8'h80;
    localparam logic [7:0] C_MULH   = 8'h40;
    localparam logic [7:0] C_MULHSU = 8'h20;
    localparam logic [7:0] C_MULHU  = 8'h10;
    localparam logic [7:0] C_DIV    = 8'h08;
    localparam logic [7:0] C_DIVU   = 8'h04;
    localparam logic [7:0] C_REM    = 8'h02;
    localparam logic [7:0] C_REMU   = 8'h01;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  c32 = '0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        v32 = 1'b0;
    logic        fl32 = 1'b0;
    logic        rdy32 = 1'b0;
    logic        ord32;
    logic [31:0] res32;
    logic        ov32;

    logic [7:0]  c8 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        v8 = 1'b0;
    logic        fl8 = 1'b0;
    logic        rdy8 = 1'b0;
    logic        ord8;
    logic [7:0]  res8;
    logic        ov8;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk               (clk),
        .rst               (rst),
        .i_MulDivControl_8 (c32),
        .i_Operand1        (a32),
        .i_Operand2        (b32),
        .i_Valid           (v32),
        .o_Ready           (ord32),
        .i_Flush           (fl32),
        .o_Result          (res32),
        .o_Valid           (ov32),
        .i_Ready           (rdy32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk               (clk),
        .rst               (rst),
        .i_MulDivControl_8 (c8),
        .i_Operand1        (a8),
        .i_Operand2        (b8),
        .i_Valid           (v8),
        .o_Ready           (ord8),
        .i_Flush           (fl8),
        .o_Result          (res8),
        .o_Valid           (ov8),
        .i_Ready           (rdy8)
    );

    typedef struct {
        string       nm;
        logic [7:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Independent RV32M reference at width w (w <= 32), using 64-bit host arithmetic.
    function automatic logic [31:0] ref_op(input int w, input logic [7:0] ctl,
                                           input logic [31:0] a, input logic [31:0] b);
        longint msk = (longint'(1) << w) - 1;
        longint ua  = longint'(a) & msk;
        longint ub  = longint'(b) & msk;
        longint sa  = ((ua >> (w - 1)) & 1) != 0 ? ua - (longint'(1) << w) : ua;
        longint sb  = ((ub >> (w - 1)) & 1) != 0 ? ub - (longint'(1) << w) : ub;
        longint mn  = -(longint'(1) << (w - 1));
        longint r;
        longint unsigned pu;
        case (ctl)
            C_MUL:    r = (ua * ub) & msk;
            C_MULH:   r = ((sa * sb) >>> w) & msk;
            C_MULHSU: r = ((sa * ub) >>> w) & msk;
            C_MULHU:  begin pu = ua * ub; r = longint'(pu >> w) & msk; end
            C_DIV:    r = (ub == 0) ? msk : (sa == mn && sb == -1) ? ua : (sa / sb) & msk;
            C_DIVU:   r = (ub == 0) ? msk : ua / ub;
            C_REM:    r = (ub == 0) ? ua : (sa == mn && sb == -1) ? 0 : (sa % sb) & msk;
            C_REMU:   r = (ub == 0) ? ua : ua % ub;
            default:  r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic issue(input bit w8, input logic [7:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
        int n = 0;
        @(negedge clk);
        while (!(w8 ? ord8 : ord32) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({nm, "_ready_timeout"}, 32'(n), 32'd0);
        if (w8) begin
            c8 = ctl; a8 = a[7:0]; b8 = b[7:0]; v8 = 1'b1;
        end else begin
            c32 = ctl; a32 = a; b32 = b; v32 = 1'b1;
        end
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v32 = 1'b0;
    endtask

    task automatic wait_valid(input bit w8, output int n);
        n = 1;
        while (!(w8 ? ov8 : ov32) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_result(input bit w8, input string nm);
        @(negedge clk);
        if (w8) rdy8 = 1'b1; else rdy32 = 1'b1;
        @(posedge clk);
        #1;
        rdy8  = 1'b0;
        rdy32 = 1'b0;
        chk({nm, "_drop"}, 32'(w8 ? ov8 : ov32), 32'd0);
    endtask

    task automatic run_op(input bit w8, input logic [7:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input string nm);
        int n;
        issue(w8, ctl, a, b, nm);
        wait_valid(w8, n);
        chk({nm, "_valid"}, 32'(w8 ? ov8 : ov32), 32'd1);
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        chk({nm, "_res"}, w8 ? {24'd0, res8} : res32, exp);
        release_result(w8, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          ok;
        logic [7:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] msk;
        int          w;
        logic        fast;

        vecs.push_back('{"mul_7xm3",   C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{"mulh_min",   C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{"mulhsu_m1",  C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{"mulhu_max",  C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{"mulh_neg",   C_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 34});
        vecs.push_back('{"mulhu_2p16", C_MULHU,  32'h00010000, 32'h00010000, 32'd1,        34});
        vecs.push_back('{"mul_2p16",   C_MUL,    32'h00010000, 32'h00010000, 32'd0,        34});
        vecs.push_back('{"div_m7_2",   C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{"rem_m7_2",   C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{"div_m7_m2",  C_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34});
        vecs.push_back('{"rem_m7_m2",  C_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34});
        vecs.push_back('{"divu_100_7", C_DIVU,   32'd100,      32'd7,        32'd14,       34});
        vecs.push_back('{"remu_100_7", C_REMU,   32'd100,      32'd7,        32'd2,        34});
        vecs.push_back('{"divu_5_10",  C_DIVU,   32'd5,        32'd10,       32'd0,        34});
        vecs.push_back('{"div_min_1",  C_DIV,    32'h80000000, 32'd1,        32'h80000000, 34});
        vecs.push_back('{"divu_by0",   C_DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"rem_by0",    C_REM,    32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{"div_ovf",    C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf",    C_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        vecs.push_back('{"ctl_zero",   8'h00,    32'h1234,     32'h5678,     32'd0,        1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ord32), 32'd0);
        chk("rst_valid", 32'(ov32), 32'd0);
        chk("rst_result", res32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ord32), 32'd1);

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   vecs[i].nm);
        end

        // Backpressure: result must hold while the consumer stalls.
        issue(1'b0, C_DIVU, 32'd100, 32'd7, "bp");
        wait_valid(1'b0, n);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ov32 !== 1'b1 || res32 !== 32'd14 || ord32 !== 1'b0) ok = 1'b0;
        end
        chk("bp_hold", 32'(ok), 32'd1);
        release_result(1'b0, "bp");
        chk("bp_idle_ready", 32'(ord32), 32'd1);
        @(negedge clk);
        c32 = C_MUL; a32 = 32'd6; b32 = 32'd7; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        chk("bp_accept_next", 32'(ord32), 32'd0);
        wait_valid(1'b0, n);
        chk("bp_next_lat", 32'(n), 32'd34);
        chk("bp_next_res", res32, 32'd42);
        release_result(1'b0, "bp_next");

        // Flush on the fifth CALC cycle.
        issue(1'b0, C_MUL, 32'd3, 32'd5, "flush");
        repeat (4) @(posedge clk);
        @(negedge clk);
        fl32 = 1'b1;
        @(posedge clk);
        #1;
        fl32 = 1'b0;
        chk("flush_idle", 32'(ord32), 32'd1);
        chk("flush_valid", 32'(ov32), 32'd0);
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov32 !== 1'b0) ok = 1'b0;
        end
        chk("flush_never_valid", 32'(ok), 32'd1);
        chk("flush_result_kept", res32, 32'd42);
        run_op(1'b0, C_MULHU, 32'h00010000, 32'h00010000, 32'd1, 34, "after_flush");

        // Reset in the middle of CALC.
        issue(1'b0, C_DIV, 32'd100, 32'd3, "rst_mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_ready", 32'(ord32), 32'd0);
        chk("rst_mid_valid", 32'(ov32), 32'd0);
        chk("rst_mid_result", res32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_idle", 32'(ord32), 32'd1);

        // Back-to-back random ops at both widths against the reference model.
        for (int k = 0; k < 32; k++) begin
            w   = (k < 16) ? 32 : 8;
            msk = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
            ctl = 8'h01 << $urandom_range(0, 7);
            a   = $urandom & msk;
            b   = $urandom & msk;
            if (k % 5 == 0) b = '0;
            if (k == 19) begin
                ctl = C_DIV; a = 32'h80; b = 32'hFF;
            end
            fast = (ctl[3:0] != 4'd0) && ((b == 32'd0) ||
                   ((ctl == C_DIV || ctl == C_REM) && a == (32'h1 << (w - 1)) && b == msk));
            run_op(w == 8, ctl, a, b, ref_op(w, ctl, a, b), fast ? 1 : w + 2,
                   $sformatf("rnd%0d_w%0d_c%02h", k, w, ctl));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
